// File: rtl/pipelined_multiplier.sv
// Valid/ready pipelined multiplier: signed/unsigned operands, low/high product half, tag passthrough.
// Defining MULT_PIPE_OVF_EN adds a registered low-half overflow flag on port ovf.
module pipelined_multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2,
    parameter int TAG_LEN        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_signed,
    input  logic                in_high,
    input  logic [TAG_LEN-1:0]  in_tag,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] result,
    output logic [TAG_LEN-1:0]  out_tag
`ifdef MULT_PIPE_OVF_EN
    ,
    output logic                ovf
`endif
);

    localparam int W2 = 2 * DATA_LEN;

    function automatic logic [W2-1:0] extend(input logic [DATA_LEN-1:0] x, input logic sgn);
        return sgn ? {{DATA_LEN{x[DATA_LEN-1]}}, x} : {{DATA_LEN{1'b0}}, x};
    endfunction

    function automatic logic [DATA_LEN-1:0] half_of(input logic [W2-1:0] p, input logic high);
        return high ? p[W2-1:DATA_LEN] : p[DATA_LEN-1:0];
    endfunction

`ifdef MULT_PIPE_OVF_EN
    function automatic logic ovf_of(input logic [W2-1:0] p, input logic sgn, input logic high);
        logic [DATA_LEN:0] top;
        // A signed low half is exact only when the upper half matches its sign bit.
        top = p[W2-1:DATA_LEN-1];
        if (high)
            return 1'b0;
        if (sgn)
            return !((&top) || !(|top));
        return |p[W2-1:DATA_LEN];
    endfunction
`endif

    logic                en;
    logic                enter_valid;
    logic                valid_q [PIPELINE_STAGE];
    logic [TAG_LEN-1:0]  tag_q   [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] result_q;
    logic [DATA_LEN-1:0] result_d;
`ifdef MULT_PIPE_OVF_EN
    logic                ovf_q;
    logic                ovf_d;
`endif

    assign out_valid = valid_q[PIPELINE_STAGE-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign result    = result_q;
    assign out_tag   = tag_q[PIPELINE_STAGE-1];
`ifdef MULT_PIPE_OVF_EN
    assign ovf       = ovf_q;
`endif

    // Valid bits and tags march together; a cycle without accept injects a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPELINE_STAGE; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else if (en) begin
            // NOTE: non-blocking assignments let every stage read the pre-edge value of its neighbour.
            valid_q[0] <= in_valid;
            if (in_valid)
                tag_q[0] <= in_tag;
            for (int i = 1; i < PIPELINE_STAGE; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    if (PIPELINE_STAGE == 1) begin : g_single
        always_comb begin
            // NOTE: every output of this block is assigned on every path, so no latch is inferred.
            result_d = half_of(extend(a, in_signed) * extend(b, in_signed), in_high);
`ifdef MULT_PIPE_OVF_EN
            ovf_d = ovf_of(extend(a, in_signed) * extend(b, in_signed), in_signed, in_high);
`endif
        end

        assign enter_valid = in_valid;
    end else begin : g_multi
        localparam int NP = PIPELINE_STAGE - 1;

        // Product split: a_ext*b_lo plus (a_lo*b_hi) << DATA_LEN, summed in the final stage.
        logic [W2-1:0]       pp_lo_q [NP];
        logic [DATA_LEN-1:0] pp_hi_q [NP];
        logic                high_q  [NP];
`ifdef MULT_PIPE_OVF_EN
        logic                sgn_q   [NP];
`endif
        logic [W2-1:0]       product;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                // NOTE: these arrays are plain flops, not RAM, so they can and must clear on reset.
                for (int i = 0; i < NP; i++) begin
                    pp_lo_q[i] <= '0;
                    pp_hi_q[i] <= '0;
                    high_q[i]  <= 1'b0;
`ifdef MULT_PIPE_OVF_EN
                    sgn_q[i]   <= 1'b0;
`endif
                end
            end else if (en) begin
                if (in_valid) begin
                    pp_lo_q[0] <= extend(a, in_signed) * {{DATA_LEN{1'b0}}, b};
                    pp_hi_q[0] <= a * (in_signed ? {DATA_LEN{b[DATA_LEN-1]}} : {DATA_LEN{1'b0}});
                    high_q[0]  <= in_high;
`ifdef MULT_PIPE_OVF_EN
                    sgn_q[0]   <= in_signed;
`endif
                end
                for (int i = 1; i < NP; i++) begin
                    pp_lo_q[i] <= pp_lo_q[i-1];
                    pp_hi_q[i] <= pp_hi_q[i-1];
                    high_q[i]  <= high_q[i-1];
`ifdef MULT_PIPE_OVF_EN
                    sgn_q[i]   <= sgn_q[i-1];
`endif
                end
            end
        end

        assign product = pp_lo_q[NP-1] + {pp_hi_q[NP-1], {DATA_LEN{1'b0}}};

        always_comb begin
            result_d = half_of(product, high_q[NP-1]);
`ifdef MULT_PIPE_OVF_EN
            ovf_d = ovf_of(product, sgn_q[NP-1], high_q[NP-1]);
`endif
        end

        assign enter_valid = valid_q[PIPELINE_STAGE-2];
    end

    // Output register loads only real operations, so result/ovf hold through stalls and bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
`ifdef MULT_PIPE_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else if (en && enter_valid) begin
            result_q <= result_d;
`ifdef MULT_PIPE_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

endmodule
